// File: rtl/shift_pkg.sv
// Shared types and line-level constants for the framed serial transmitter.
package shift_pkg;

  // Frame sequencer states, in the order they occur on the line.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Level of the serial line between frames (and of the stop bit).
  localparam logic LINE_IDLE = 1'b1;
  // Level of the start bit that opens every frame.
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the last cycle
// of each serial bit, which is where the sequencer advances.
module bit_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  // A 1-bit counter is kept even for DIV=1 so the compare stays legal.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  // Divider count: clear has priority, otherwise wrap at DIV-1 while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      if (r_count == LAST) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end else begin
      r_count <= r_count;
    end
  end

  // Boundary tick is high for exactly one cycle per bit period.
  assign o_tick = i_en && (r_count == LAST);

endmodule

// File: rtl/piso_frame_ctrl.sv
// Framed serial transmitter: takes a word over valid/ready, then drives
// start bit, data bits (LSB- or MSB-first), optional even parity and a stop
// bit onto a registered serial line, each bit held for DIV clocks.
module piso_frame_ctrl #(
  parameter int DATA_W    = 8,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 0,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              serial_out,
  output logic              busy,
  output logic              done
);

  import shift_pkg::*;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            r_state, w_state_next;
  logic [DATA_W-1:0] r_shreg, w_shreg_next;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
  logic              r_parity, w_parity_next;
  logic              r_line, w_line_next;
  logic              r_done, w_done_next;
  logic              w_accept;
  logic              w_busy;
  logic              w_tick;
  logic              w_div_clear;

  // Even parity over the captured word.
  function automatic logic even_parity(input logic [DATA_W-1:0] v);
    even_parity = ^v;
  endfunction

  // Move the next data bit into the output position.
  function automatic logic [DATA_W-1:0] shift_once(input logic [DATA_W-1:0] v);
    if (MSB_FIRST != 0) begin
      shift_once = v << 1'b1;
    end else begin
      shift_once = v >> 1'b1;
    end
  endfunction

  // Bit currently at the output end of the shift register.
  function automatic logic out_bit(input logic [DATA_W-1:0] v);
    if (MSB_FIRST != 0) begin
      out_bit = v[DATA_W-1];
    end else begin
      out_bit = v[0];
    end
  endfunction

  assign w_busy      = (r_state != IDLE);
  assign in_ready    = (r_state == IDLE) && !abort;
  assign w_accept    = in_valid && in_ready;
  // Divider restarts on every new frame, on abort, and is parked while idle.
  assign w_div_clear = w_accept || abort || !w_busy;

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_div_clear),
    .i_en    (w_busy),
    .o_tick  (w_tick)
  );

  // Next-state, datapath update and next line level for the frame sequencer.
  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = r_shreg;
    w_bit_cnt_next = r_bit_cnt;
    w_parity_next  = r_parity;
    w_done_next    = 1'b0;
    w_line_next    = LINE_IDLE;

    if (abort && w_busy) begin
      w_state_next   = IDLE;
      w_bit_cnt_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_shreg_next   = in_data;
            w_parity_next  = even_parity(in_data);
            w_bit_cnt_next = '0;
            w_state_next   = START;
          end else begin
            w_state_next   = IDLE;
          end
        end
        START: begin
          if (w_tick) begin
            w_state_next = DATA;
          end else begin
            w_state_next = START;
          end
        end
        DATA: begin
          if (w_tick) begin
            w_shreg_next   = shift_once(r_shreg);
            w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == LAST_BIT) begin
              w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              w_state_next = DATA;
            end
          end else begin
            w_state_next = DATA;
          end
        end
        PARITY: begin
          if (w_tick) begin
            w_state_next = STOP;
          end else begin
            w_state_next = PARITY;
          end
        end
        STOP: begin
          if (w_tick) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = STOP;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end

    // Line level is chosen from the state being entered so the registered
    // output shows that state's bit from its very first cycle.
    case (w_state_next)
      START:   w_line_next = START_BIT;
      DATA:    w_line_next = out_bit(w_shreg_next);
      PARITY:  w_line_next = w_parity_next;
      default: w_line_next = LINE_IDLE;
    endcase
  end

  // Sequencer state, shift register, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_line    <= LINE_IDLE;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_parity  <= w_parity_next;
      r_line    <= w_line_next;
      r_done    <= w_done_next;
    end
  end

  assign serial_out = r_line;
  assign busy       = w_busy;
  assign done       = r_done;

endmodule
